fp_useq: RTL and testbench

//  Microcode sequencer for the FPU microcode ROM pair (192 x 2 x 64b, 1-cycle registered read, output holds when not enabled).

---
 rtl/fp_useq_pkg.sv | 36 +++
 rtl/fp_useq_nxt.sv | 67 ++++++
 rtl/fp_useq.sv | 115 +++++++++++
 tb/tb_fp_useq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_useq_pkg.sv
// Shared encodings for the FPU microcode sequencer: sequencing-field layout,
// next-address codes, FSM states and ROM address limits.
package fp_useq_pkg;

    localparam int ROM_DEPTH = 192;
    localparam int AW        = 8;

    // First illegal address, widened by one bit so upc+1 never wraps.
    localparam logic [AW:0] ADR_LIM = ROM_DEPTH[AW:0];

    typedef enum logic [1:0] {
        NXT_SEQ = 2'b00,
        NXT_JMP = 2'b01,
        NXT_BR  = 2'b10,
        NXT_END = 2'b11
    } nxt_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;

    // do1[15:0] sequencing field, MSB first.
    typedef struct packed {
        nxt_e          nxt;
        logic [2:0]    cond_sel;
        logic          inv;
        logic          call;
        logic          ret;
        logic [AW-1:0] target;
    } seq_t;

    function automatic logic [AW:0] adr_inc(input logic [AW-1:0] a);
        return {1'b0, a} + 1'b1;
    endfunction

endpackage

// File: rtl/fp_useq_nxt.sv
// Combinational next-address decode for the microcode sequencer.
// Loop-counter decode is present only when FPU_USEQ_LOOP_EN is defined.
module fp_useq_nxt
    import fp_useq_pkg::*;
(
    input  logic [15:0]   seq,
    input  logic [AW-1:0] upc,
    input  logic [AW-1:0] ret_reg,
    input  logic [7:0]    cond,
    input  logic [5:0]    cnt,
    output logic [AW-1:0] nxt_adr,
    output logic [AW-1:0] ret_val,
    output logic          is_end,
    output logic          illegal,
    output logic          ret_wr,
    output logic          cnt_ld,
    output logic          cnt_dec
);

    seq_t        f;
    logic [AW:0] inc;
    logic [AW:0] adr;
    logic        jcr;
    logic        cbit;
    logic        taken;

    assign f   = seq_t'(seq);
    assign inc = adr_inc(upc);
    // JMP with call and ret both set is the loop-load form, never a real call/return.
    assign jcr = (f.nxt == NXT_JMP) && f.call && f.ret;

`ifdef FPU_USEQ_LOOP_EN
    assign cbit    = (&f.cond_sel) ? (cnt != 6'd0) : cond[f.cond_sel];
    assign cnt_ld  = jcr;
    assign cnt_dec = taken && (&f.cond_sel) && (cnt != 6'd0);
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt;
    assign cbit    = cond[f.cond_sel];
    assign cnt_ld  = 1'b0;
    assign cnt_dec = 1'b0;
`endif

    assign taken = (f.nxt == NXT_BR) && (cbit ^ f.inv);

    always_comb begin
        adr    = inc;
        ret_wr = 1'b0;
        if (jcr) begin
            adr = cnt_ld ? inc : {1'b0, f.target};
        end else begin
            case (f.nxt)
                NXT_JMP: adr = {1'b0, f.target};
                NXT_BR:  if (taken) adr = {1'b0, f.target};
                default: ;
            endcase
            ret_wr = f.call && ((f.nxt == NXT_JMP) || taken);
            if (f.ret && (f.nxt != NXT_END)) adr = {1'b0, ret_reg};
        end
    end

    assign nxt_adr = adr[AW-1:0];
    assign ret_val = inc[AW-1:0];
    assign is_end  = (f.nxt == NXT_END);
    assign illegal = !is_end && (adr >= ADR_LIM);

endmodule

// File: rtl/fp_useq.sv
// FPU microcode sequencer: drives the 192x128b ROM pair and presents microwords.
// Define FPU_USEQ_LOOP_EN to build the 6-bit loop counter.
module fp_useq
    import fp_useq_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] entry_adr,
    input  logic          stall,
    input  logic [7:0]    cond,
    input  logic [63:0]   do1,
    input  logic [63:0]   do0,
    output logic          rom_en,
    output logic [AW-1:0] rom_adr,
    output logic [127:0]  uword,
    output logic          uword_vld,
    output logic          busy,
    output logic          done,
    output logic          err
);

    logic [1:0]    state;
    logic [AW-1:0] upc;
    logic [AW-1:0] ret_reg;
    logic [AW-1:0] nxt_adr;
    logic [AW-1:0] ret_val;
    logic [5:0]    cnt;
    logic          is_end;
    logic          illegal;
    logic          ret_wr;
    logic          cnt_ld;
    logic          cnt_dec;
    logic          exec;
    logic          adv;
    logic          step;

    fp_useq_nxt u_nxt (
        .seq     (do1[15:0]),
        .upc     (upc),
        .ret_reg (ret_reg),
        .cond    (cond),
        .cnt     (cnt),
        .nxt_adr (nxt_adr),
        .ret_val (ret_val),
        .is_end  (is_end),
        .illegal (illegal),
        .ret_wr  (ret_wr),
        .cnt_ld  (cnt_ld),
        .cnt_dec (cnt_dec)
    );

    assign exec      = (state == ST_EXEC);
    assign adv       = exec && !stall;
    assign step      = adv && !is_end && !illegal;
    assign uword     = {do1, do0};
    assign uword_vld = adv;
    assign busy      = (state != ST_IDLE);
    // In EXEC the next address goes straight to the ROM so it streams one word per cycle.
    assign rom_en    = (state == ST_FETCH) || step;
    assign rom_adr   = exec ? nxt_adr : upc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            upc     <= '0;
            ret_reg <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        upc <= entry_adr;
                        err <= ({1'b0, entry_adr} >= ADR_LIM);
                        if ({1'b0, entry_adr} < ADR_LIM) state <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_EXEC;
                ST_EXEC: begin
                    if (!stall) begin
                        if (is_end) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else if (illegal) begin
                            state <= ST_IDLE;
                            err   <= 1'b1;
                        end else begin
                            upc <= nxt_adr;
                            if (ret_wr) ret_reg <= ret_val;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FPU_USEQ_LOOP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (step) begin
            if (cnt_ld)       cnt <= do1[5:0];
            else if (cnt_dec) cnt <= cnt - 6'd1;
        end
    end
`else
    logic unused_loop;
    assign cnt         = '0;
    assign unused_loop = cnt_ld | cnt_dec;
`endif

endmodule

// File: tb/tb_fp_useq.sv
// Self-checking bench for fp_useq: directed tables, cycle tables, randomized ops vs interpreter.
module tb_fp_useq;

`ifdef FPU_USEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic         clk, reset, start, stall;
    logic [7:0]   entry_adr, cond;
    logic [63:0]  do1, do0;
    logic         rom_en, uword_vld, busy, done, err;
    logic [7:0]   rom_adr;
    logic [127:0] uword;

    fp_useq dut (
        .clk(clk), .reset(reset), .start(start), .entry_adr(entry_adr), .stall(stall),
        .cond(cond), .do1(do1), .do0(do0), .rom_en(rom_en), .rom_adr(rom_adr),
        .uword(uword), .uword_vld(uword_vld), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] rom1 [256];
    logic [63:0] rom0 [256];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            do1 <= '0;
            do0 <= '0;
        end else if (rom_en) begin
            do1 <= rom1[rom_adr];
            do0 <= rom0[rom_adr];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] mkseq(input logic [1:0] nxt, input int sel, input bit inv,
                                          input bit call, input bit ret, input logic [7:0] tgt);
        return {nxt, 3'(sel), inv, call, ret, tgt};
    endfunction

    // do0[7:0] tags each word with its own address so the bench can see what executed.
    task automatic put(input int a, input logic [15:0] s);
        rom1[a] = {$urandom(), 16'(a), s};
        rom0[a] = {$urandom(), 24'(~a), 8'(a)};
    endtask

    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    bit saw_done, timed_out;
    int stall_bad;

    task automatic run_op(input logic [7:0] e, input logic [7:0] c, input int spct);
        obs_q.delete();
        saw_done = 0; timed_out = 1; stall_bad = 0;
        @(posedge clk); #1;
        entry_adr = e; cond = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            stall = ($urandom_range(99) < 32'(spct));
            @(negedge clk);
            if (uword_vld) obs_q.push_back(uword[7:0]);
            if (stall && (uword_vld || (k > 0 && busy && rom_en))) stall_bad++;
            if (!busy) begin
                saw_done = done; timed_out = 0;
                break;
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
    endtask

    task automatic chk_trace(input string nm);
        int bad_i;
        bad_i = -1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (bad_i < 0 && obs_q[i] !== exp_q[i]) bad_i = i;
        checks++;
        if (bad_i >= 0 || obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_trace: got %0d words, want %0d words, first diff at %0d (got %0h want %0h)",
                     nm, obs_q.size(), exp_q.size(), bad_i,
                     (bad_i >= 0) ? obs_q[bad_i] : 8'h0, (bad_i >= 0) ? exp_q[bad_i] : 8'h0);
        end
    endtask

    // Interpreter of the microcode rules; returns ok=0 if the program does not finish in 60 words.
    task automatic model(input logic [7:0] e, input logic [7:0] c, inout logic [7:0] r,
                         inout logic [5:0] n, output bit err_o, output bit ok);
        logic [8:0] pc, nx;
        logic [15:0] s;
        logic [7:0] nr;
        logic [5:0] nn;
        bit taken, cb;
        exp_q.delete();
        pc = {1'b0, e}; ok = 0; err_o = 0;
        for (int step = 0; step < 60; step++) begin
            exp_q.push_back(pc[7:0]);
            s = rom1[pc[7:0]][15:0];
            if (s[15:14] == 2'b11) begin ok = 1; return; end
            nr = r; nn = n;
            if (s[15:14] == 2'b01 && s[9] && s[8]) begin
                if (LOOP) begin nn = s[5:0]; nx = pc + 9'd1; end
                else nx = {1'b0, s[7:0]};
            end else begin
                cb = (LOOP && s[13:11] == 3'd7) ? (n != 0) : c[s[13:11]];
                taken = (s[15:14] == 2'b10) && (cb ^ s[10]);
                if (taken && LOOP && s[13:11] == 3'd7 && n != 0) nn = n - 6'd1;
                nx = (s[15:14] == 2'b01 || taken) ? {1'b0, s[7:0]} : pc + 9'd1;
                if (s[9] && (s[15:14] == 2'b01 || taken)) nr = pc[7:0] + 8'd1;
                if (s[8]) nx = {1'b0, r};
            end
            if (nx >= 9'd192) begin err_o = 1; ok = 1; return; end
            pc = nx; r = nr; n = nn;
        end
    endtask

    typedef struct {
        string      nm;
        logic [7:0] entry;
        logic [7:0] cnd;
        int         n;
        logic [63:0] tr;
        bit         eerr;
    } vec_t;

    typedef struct {
        bit st; bit stl; bit en; logic [7:0] adr; bit cadr;
        bit vld; logic [7:0] tag; bit ctag; bit dn; bit bz;
    } cyc_t;

    vec_t vt[$];
    cyc_t cy[$];

    task automatic run_cyc(input string nm);
        logic [127:0] prev_uw;
        prev_uw = '0;
        @(posedge clk); #1;
        entry_adr = 8'h10; cond = 8'h00; start = 1'b1; stall = 1'b0;
        for (int k = 0; k < cy.size(); k++) begin
            @(posedge clk); #1;
            start = cy[k].st; stall = cy[k].stl;
            @(negedge clk);
            chk($sformatf("%s_c%0d_ctl", nm, k + 1), 128'({rom_en, uword_vld, done, busy}),
                128'({cy[k].en, cy[k].vld, cy[k].dn, cy[k].bz}));
            if (cy[k].cadr) chk($sformatf("%s_c%0d_adr", nm, k + 1), 128'(rom_adr), 128'(cy[k].adr));
            if (cy[k].ctag) chk($sformatf("%s_c%0d_tag", nm, k + 1), 128'(uword[7:0]), 128'(cy[k].tag));
            if (k > 0 && cy[k].stl && cy[k-1].stl) chk($sformatf("%s_c%0d_hold", nm, k + 1), uword, prev_uw);
            prev_uw = uword;
        end
        start = 1'b0; stall = 1'b0;
    endtask

    logic [7:0] m_ret;
    logic [5:0] m_cnt;

    initial begin
        logic [7:0] tr8, ec;
        logic [5:0] tn;
        bit eerr, ok;
        int nops, r;
        logic [1:0] nx;

        reset = 1'b1; start = 1'b0; stall = 1'b0; entry_adr = '0; cond = '0;
        for (int a = 0; a < 256; a++) put(a, mkseq(2'b11, 0, 0, 0, 0, 8'h00));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_state", 128'({rom_en, rom_adr, uword_vld, busy, done, err}), 128'(0));

        put(8'h10, mkseq(2'b00, 0, 0, 0, 0, 8'h00));
        put(8'h11, mkseq(2'b00, 0, 0, 0, 0, 8'h00));
        put(8'h12, mkseq(2'b00, 0, 0, 0, 0, 8'h00));
        put(8'h20, mkseq(2'b10, 2, 0, 0, 0, 8'h40));
        put(8'h28, mkseq(2'b10, 2, 1, 0, 0, 8'h40));
        put(8'h30, mkseq(2'b01, 0, 0, 1, 0, 8'h50));
        put(8'h50, mkseq(2'b00, 0, 0, 0, 0, 8'h00));
        put(8'h51, mkseq(2'b00, 0, 0, 0, 1, 8'h00));
        put(8'hBE, mkseq(2'b00, 0, 0, 0, 0, 8'h00));
        put(8'hBF, mkseq(2'b00, 0, 0, 0, 0, 8'h00));
        put(8'h60, mkseq(2'b01, 0, 0, 0, 0, 8'hC8));
        put(8'h80, mkseq(2'b01, 0, 0, 1, 1, 8'h04));
        put(8'h81, mkseq(2'b10, 7, 0, 0, 0, 8'h81));

        vt.push_back('{"straight",  8'h10, 8'h00, 4, 64'({8'h13, 8'h12, 8'h11, 8'h10}), 1'b0});
        vt.push_back('{"br_taken",  8'h20, 8'h04, 2, 64'({8'h40, 8'h20}), 1'b0});
        vt.push_back('{"br_not",    8'h20, 8'hFB, 2, 64'({8'h21, 8'h20}), 1'b0});
        vt.push_back('{"br_inv",    8'h28, 8'h04, 2, 64'({8'h29, 8'h28}), 1'b0});
        vt.push_back('{"br_inv_tk", 8'h28, 8'h00, 2, 64'({8'h40, 8'h28}), 1'b0});
        vt.push_back('{"call_ret",  8'h30, 8'h00, 4, 64'({8'h31, 8'h51, 8'h50, 8'h30}), 1'b0});
`ifdef FPU_USEQ_LOOP_EN
        vt.push_back('{"loop5",     8'h80, 8'h00, 7,
                       64'({8'h82, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h80}), 1'b0});
`else
        vt.push_back('{"jcr_plain", 8'h80, 8'hFF, 2, 64'({8'h04, 8'h80}), 1'b0});
`endif
        vt.push_back('{"ill_seq",   8'hBE, 8'h00, 2, 64'({8'hBF, 8'hBE}), 1'b1});
        vt.push_back('{"ill_jmp",   8'h60, 8'h00, 1, 64'({8'h60}), 1'b1});

        foreach (vt[i]) begin
            run_op(vt[i].entry, vt[i].cnd, 0);
            exp_q.delete();
            for (int j = 0; j < vt[i].n; j++) exp_q.push_back(vt[i].tr[8*j +: 8]);
            chk({vt[i].nm, "_timeout"}, 128'(timed_out), 128'(0));
            chk_trace(vt[i].nm);
            chk({vt[i].nm, "_outcome"}, 128'({saw_done, err}), 128'(vt[i].eerr ? 2'b01 : 2'b10));
        end

        // Start held during the op and on the END cycle must be ignored.
        cy.delete();
        cy.push_back('{0, 0, 1, 8'h10, 1, 0, 8'h00, 0, 0, 1});
        cy.push_back('{0, 0, 1, 8'h11, 1, 1, 8'h10, 1, 0, 1});
        cy.push_back('{1, 0, 1, 8'h12, 1, 1, 8'h11, 1, 0, 1});
        cy.push_back('{1, 0, 1, 8'h13, 1, 1, 8'h12, 1, 0, 1});
        cy.push_back('{1, 0, 0, 8'h00, 0, 1, 8'h13, 1, 0, 1});
        cy.push_back('{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0});
        cy.push_back('{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0});
        run_cyc("timing");

        // Stall in FETCH is ignored; 3-cycle stall mid-EXEC freezes everything.
        cy.delete();
        cy.push_back('{0, 1, 1, 8'h10, 1, 0, 8'h00, 0, 0, 1});
        cy.push_back('{0, 0, 1, 8'h11, 1, 1, 8'h10, 1, 0, 1});
        cy.push_back('{0, 1, 0, 8'h00, 0, 0, 8'h11, 1, 0, 1});
        cy.push_back('{0, 1, 0, 8'h00, 0, 0, 8'h11, 1, 0, 1});
        cy.push_back('{0, 1, 0, 8'h00, 0, 0, 8'h11, 1, 0, 1});
        cy.push_back('{0, 0, 1, 8'h12, 1, 1, 8'h11, 1, 0, 1});
        cy.push_back('{0, 0, 1, 8'h13, 1, 1, 8'h12, 1, 0, 1});
        cy.push_back('{0, 0, 0, 8'h00, 0, 1, 8'h13, 1, 0, 1});
        cy.push_back('{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0});
        run_cyc("stall");

        run_op(8'h60, 8'h00, 0);
        chk("err_sticky", 128'(err), 128'(1));
        @(posedge clk); #1;
        entry_adr = 8'h10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("err_clr_on_start", 128'(err), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_exec", 128'({busy, uword_vld}), 128'(2'b11));
        #1 reset = 1'b1;
        #1;
        chk("reset_mid_exec", 128'({rom_en, rom_adr, uword_vld, busy, done, err}), 128'(0));
        @(posedge clk); #1 reset = 1'b0;
        m_ret = '0; m_cnt = '0;

        for (int a = 0; a < 192; a++) begin
            r = int'($urandom_range(99));
            nx = (r < 45) ? 2'b00 : (r < 60) ? 2'b01 : (r < 82) ? 2'b10 : 2'b11;
            tr8 = ($urandom_range(9) == 0) ? 8'($urandom_range(255, 192)) : 8'($urandom_range(191));
            put(a, mkseq(nx, int'($urandom_range(7)), bit'($urandom_range(1)),
                         $urandom_range(9) == 0, $urandom_range(11) == 0, tr8));
        end

        nops = 0;
        for (int t = 0; t < 400 && nops < 40; t++) begin
            tr8 = 8'($urandom_range(191));
            ec = 8'($urandom());
            begin
                logic [7:0] rr;
                rr = m_ret; tn = m_cnt;
                model(tr8, ec, rr, tn, eerr, ok);
                if (ok) begin
                    m_ret = rr; m_cnt = tn;
                    nops++;
                    run_op(tr8, ec, 30);
                    chk($sformatf("rnd%0d_timeout", nops), 128'(timed_out), 128'(0));
                    chk_trace($sformatf("rnd%0d", nops));
                    chk($sformatf("rnd%0d_outcome", nops), 128'({saw_done, err}),
                        128'(eerr ? 2'b01 : 2'b10));
                    chk($sformatf("rnd%0d_stall", nops), 128'(stall_bad), 128'(0));
                end
            end
        end
        chk("rnd_ops_run", 128'(nops), 128'(40));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
